core_step_ctrl: RTL
===================

// Module: core_step_ctrl
//
// PURPOSE
// Generates the core's clock-enable from the fast board clock, replacing ad-hoc divided clocks feeding the datapath.
// RUN mode: periodic enable pulse every RUN_DIV cycles (RUN_DIV=2 equals the existing divide-by-2 rate).
// STEP mode: exactly one enable pulse per debounced press of the step push-button.
// Sits between the board clock/button/switch inputs and the processor's register/PC enables.
//
// PARAMETERS
// DEBOUNCE_CYCLES  16     consecutive clk cycles a synced button level must hold before btn_db follows it (>=2)
// RUN_DIV          2      clk cycles between core_en pulses in RUN mode (>=1; 1 = every cycle)
// CNT_W            16     width of step_count
//
// PORTS
// clk          in   1      fast board clock; all logic on posedge
// rst          in   1      asynchronous reset, active-low (0 = reset)
// btn_step     in   1      raw step push-button, asynchronous, active-high, bouncy
// sw_run       in   1      raw mode switch, asynchronous; 1 = RUN, 0 = STEP
// core_en      out  1      one-clk-wide enable pulse to the core
// step_count   out  CNT_W  number of core_en pulses issued since reset
// btn_db       out  1      debounced button level (for LED / debug)
// run_mode     out  1      1 while FSM is in RUN
//
// BEHAVIOUR
// Reset (rst=0, async assert, sync release): core_en=0, step_count=0, btn_db=0, run_mode=0,
//   synchronizer flops=0, debounce counter=0, divider counter=0, FSM=STEP_WAIT.
// Synchronizers: btn_step and sw_run each pass through 2 flops -> btn_s, sw_s (2-cycle latency).
// Debounce: counter clears whenever btn_s==btn_db; increments while btn_s!=btn_db;
//   when it reaches DEBOUNCE_CYCLES-1 with btn_s still !=btn_db, btn_db<=btn_s and counter<=0.
//   Any glitch back to btn_db before that restarts the count. Only sw_s is not debounced.
// FSM states: STEP_WAIT, STEP_HOLD, RUN.
//   STEP_WAIT: sw_s=1 -> RUN; else btn_db=1 -> STEP_HOLD and core_en=1 for that single transition cycle.
//   STEP_HOLD: sw_s=1 -> RUN; else btn_db=0 -> STEP_WAIT; else stay. No pulses while held.
//   RUN: sw_s=0 -> STEP_HOLD if btn_db=1, else STEP_WAIT. core_en from divider only.
//   sw_s has priority over button in every state (simultaneous press and mode change -> mode wins, no pulse).
// Divider (RUN only): counter 0..RUN_DIV-1, cleared on every entry to RUN and in non-RUN states;
//   core_en=1 in the cycle counter==RUN_DIV-1, then counter wraps to 0.
//   First pulse occurs RUN_DIV cycles after the state becomes RUN; pulses then every RUN_DIV cycles.
//   Leaving RUN mid-count: counter cleared, no partial pulse, no pulse in the exit cycle.
// core_en is registered (driven from flops), never wider than 1 cycle, never two pulses on back-to-back
//   cycles unless RUN_DIV=1.
// step_count increments by 1 in the same cycle core_en is registered high; wraps all-ones -> 0 silently.
// run_mode is registered = (state==RUN).
// Reset mid-operation: all state returns to reset values immediately; a button held through reset release
//   must debounce high then produce exactly one pulse (press counted once).
//
// TESTING
// (Bench: DEBOUNCE_CYCLES=4, RUN_DIV=2, CNT_W=16.)
// 1 STEP press: sw_run=0, btn_step 0->1 held 20 cycles -> btn_db high 2+4 cycles later, exactly one core_en,
//   step_count=1; release and re-press -> step_count=2.
// 2 Bounce: btn_step toggles every 2 cycles for 30 cycles then held high -> btn_db never toggles during
//   bounce, single core_en after settling, step_count=1.
// 3 RUN rate: sw_run=1 for 100 cycles after sync -> core_en every 2nd cycle, 50 pulses (+/-1 by sync edge),
//   run_mode=1; sw_run=0 -> no further pulses, count frozen.
// 4 Mode vs button: button held while sw_run 1->0 -> FSM STEP_HOLD, zero pulses until release+new press.
// 5 Wrap: force step_count to 16'hFFFF, one step press -> step_count=16'h0000, core_en=1 once.
// 6 Reset mid-RUN: rst=0 for 3 cycles during RUN -> core_en=0, step_count=0, run_mode=0 asynchronously;
//   after release with sw_run=1, first core_en 2+2 cycles post-sync.

Source files
------------

// File: rtl/core_step_ctrl.sv
// Core clock-enable generator: free-running divided enable in RUN mode, one enable per
// debounced button press in STEP mode.
module core_step_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned RUN_DIV         = 2,
   parameter int unsigned CNT_W           = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_step,
   input  logic             sw_run,
   output logic             core_en,
   output logic [CNT_W-1:0] step_count,
   output logic             btn_db,
   output logic             run_mode
);

   localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned DivW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

   typedef enum logic [1:0] {StStepWait, StStepHold, StRun} state_e;

   logic [1:0]       btn_sync_q, sw_sync_q;
   logic             btn_s, sw_s;
   logic [DbW-1:0]   db_cnt_q, db_cnt_d;
   logic             btn_db_q, btn_db_d;
   state_e           state_q, state_d;
   logic [DivW-1:0]  div_q, div_d;
   logic             core_en_q, core_en_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             run_mode_q;

   assign btn_s = btn_sync_q[1];
   assign sw_s  = sw_sync_q[1];

   // Any sample matching the current debounced level restarts the hold count.
   always_comb begin
      db_cnt_d = '0;
      btn_db_d = btn_db_q;
      if (btn_s != btn_db_q) begin
         if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
            btn_db_d = btn_s;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   // Mode switch outranks the button; the divider only runs while staying in RUN.
   always_comb begin
      state_d   = state_q;
      div_d     = '0;
      core_en_d = 1'b0;
      case (state_q)
         StStepWait: begin
            if (sw_s) begin
               state_d = StRun;
            end else if (btn_db_q) begin
               state_d   = StStepHold;
               core_en_d = 1'b1;
            end
         end
         StStepHold: begin
            if (sw_s) begin
               state_d = StRun;
            end else if (!btn_db_q) begin
               state_d = StStepWait;
            end
         end
         StRun: begin
            if (!sw_s) begin
               state_d = btn_db_q ? StStepHold : StStepWait;
            end else if (div_q == DivW'(RUN_DIV - 1)) begin
               core_en_d = 1'b1;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: state_d = StStepWait;
      endcase
   end

   assign count_d = count_q + CNT_W'(core_en_d);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_sync_q <= '0;
         sw_sync_q  <= '0;
         db_cnt_q   <= '0;
         btn_db_q   <= 1'b0;
         state_q    <= StStepWait;
         div_q      <= '0;
         core_en_q  <= 1'b0;
         count_q    <= '0;
         run_mode_q <= 1'b0;
      end else begin
         btn_sync_q <= {btn_sync_q[0], btn_step};
         sw_sync_q  <= {sw_sync_q[0], sw_run};
         db_cnt_q   <= db_cnt_d;
         btn_db_q   <= btn_db_d;
         state_q    <= state_d;
         div_q      <= div_d;
         core_en_q  <= core_en_d;
         count_q    <= count_d;
         run_mode_q <= (state_d == StRun);
      end
   end

   assign core_en    = core_en_q;
   assign step_count = count_q;
   assign btn_db     = btn_db_q;
   assign run_mode   = run_mode_q;

endmodule
